// File: rtl/bnn_xnor_accumulate.sv
// Binarized-network XNOR/popcount accumulator: per-lane accumulation over a programmed
// number of beats, then a per-lane threshold compare into one 32-bit result word per job.
module bnn_xnor_accumulate #(
  parameter int LANES = 32,
  parameter int WIDTH = 16,
  parameter int ACC_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [5:0]               batch,
  input  logic [LANES*ACC_W-1:0]   threshold,
  input  logic [LANES*WIDTH-1:0]   activation_in,
  input  logic [LANES-1:0]         activation_in_valid,
  input  logic [LANES*WIDTH-1:0]   weight_in,
  output logic [LANES-1:0]         out_bits,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PC_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;

  state_t                   state_reg;
  logic [5:0]               batch_reg;
  logic [LANES*ACC_W-1:0]   threshold_reg;
  logic [LANES-1:0]         out_bits_reg;
  logic                     out_valid_reg;
  logic                     busy_reg;
  logic                     overrun_reg;

  logic [LANES-1:0] pv_vec;
  logic [LANES-1:0] done_vec;
  logic [LANES-1:0] lane_accept;
  logic [LANES-1:0] lane_drop;
  logic [LANES-1:0] lane_ge;
  logic             running;
  logic             job_start;

  assign running   = (state_reg == RUN);
  assign job_start = (state_reg == IDLE) && start;

  function automatic logic [PC_W-1:0] xnor_popcount(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] w);
    logic [PC_W-1:0] n;
    n = '0;
    for (int k = 0; k < WIDTH; k++) begin
      n = n + PC_W'(~(a[k] ^ w[k]));
    end
    return n;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PC_W-1:0]  pc_reg;
      logic             pv_reg;
      logic [ACC_W-1:0] acc_reg;
      logic [5:0]       cnt_reg;
      logic             done_reg;
      logic             last_in_flight;

      // The final beat sitting in stage 2 closes the lane a cycle before done rises,
      // so a trailing beat is refused at stage 1 instead of being accumulated.
      assign last_in_flight  = pv_reg && (cnt_reg == batch_reg);
      assign lane_accept[gi] = running && activation_in_valid[gi] && !done_reg && !last_in_flight;
      assign lane_drop[gi]   = activation_in_valid[gi] && !lane_accept[gi];
      assign lane_ge[gi]     = (acc_reg >= threshold_reg[ACC_W*gi +: ACC_W]);
      assign pv_vec[gi]      = pv_reg;
      assign done_vec[gi]    = done_reg;

      always_ff @(posedge clk) begin
        if (rst || job_start) begin
          pc_reg   <= '0;
          pv_reg   <= 1'b0;
          acc_reg  <= '0;
          cnt_reg  <= '0;
          done_reg <= 1'b0;
        end else begin
          pv_reg <= lane_accept[gi];
          if (lane_accept[gi]) begin
            pc_reg <= xnor_popcount(activation_in[WIDTH*gi +: WIDTH], weight_in[WIDTH*gi +: WIDTH]);
          end
          if (pv_reg) begin
            acc_reg <= acc_reg + ACC_W'(pc_reg);
            cnt_reg <= cnt_reg + 6'd1;
            if (cnt_reg == batch_reg) begin
              done_reg <= 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      batch_reg     <= '0;
      threshold_reg <= '0;
      out_bits_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      // A start clears the sticky flag, but valids landing in that same cycle re-set it.
      if (job_start) begin
        overrun_reg <= |lane_drop;
      end else if (|lane_drop) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            batch_reg     <= batch;
            threshold_reg <= threshold;
            busy_reg      <= 1'b1;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          if ((&done_vec) && !(|pv_vec)) begin
            out_bits_reg  <= lane_ge;
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= EMIT;
          end
        end
        EMIT: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign out_bits  = out_bits_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_bnn_xnor_accumulate.sv
// Bench for bnn_xnor_accumulate: table of uniform jobs plus hand sequences for skew,
// overrun, start-while-running and mid-job reset; results go through a scoreboard queue.
module tb_bnn_xnor_accumulate;
  localparam int LANES = 32;
  localparam int WIDTH = 16;
  localparam int ACC_W = 11;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [5:0]             batch;
  logic [LANES*ACC_W-1:0] threshold;
  logic [LANES*WIDTH-1:0] activation_in;
  logic [LANES-1:0]       activation_in_valid;
  logic [LANES*WIDTH-1:0] weight_in;
  logic [LANES-1:0]       out_bits;
  logic                   out_valid;
  logic                   busy;
  logic                   overrun;

  bnn_xnor_accumulate #(.LANES(LANES), .WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .batch(batch), .threshold(threshold),
    .activation_in(activation_in), .activation_in_valid(activation_in_valid),
    .weight_in(weight_in), .out_bits(out_bits), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int out_cnt = 0;
  int last_out_cyc = 0;
  int last_valid_cyc = 0;
  logic [LANES-1:0] exp_q[$];
  logic [LANES-1:0] mon_exp;

  typedef struct {
    logic [5:0]       batch;
    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] w;
    logic [ACC_W-1:0] thr_even;
    logic [ACC_W-1:0] thr_odd;
    logic [LANES-1:0] exp_bits;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard pop whenever the DUT emits a result.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      out_cnt++;
      last_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_out: out_valid with out_bits=%0h but no job expected (cycle %0d)", out_bits, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_out_bits", 64'(out_bits), 64'(mon_exp));
        check("busy_at_out_valid", 64'(busy), 64'(0));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_thr(input logic [ACC_W-1:0] te, input logic [ACC_W-1:0] to);
    for (int i = 0; i < LANES; i++) begin
      threshold[ACC_W*i +: ACC_W] = (i % 2 == 0) ? te : to;
    end
  endtask

  // Start pulse, then scramble batch/threshold so only latched values can give correct results.
  task automatic start_job(input logic [5:0] b, input logic [ACC_W-1:0] te, input logic [ACC_W-1:0] to);
    batch = b;
    set_thr(te, to);
    start = 1'b1;
    tick();
    start = 1'b0;
    batch = ~b;
    threshold = '1;
  endtask

  task automatic drive_beat(input logic [LANES-1:0] v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] w);
    activation_in_valid = v;
    activation_in = {LANES{a}};
    weight_in = {LANES{w}};
    last_valid_cyc = cyc;
    tick();
  endtask

  task automatic wait_out(input int prev, input int budget);
    for (int k = 0; k < budget && out_cnt == prev; k++) tick();
    if (out_cnt == prev) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_valid_timeout: no out_valid within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    logic [LANES-1:0] vmask;

    vecs[0] = '{6'd0,  16'hFFFF, 16'hFFFF, 11'd8,    11'd8,    32'hFFFF_FFFF};
    vecs[1] = '{6'd3,  16'h00FF, 16'h0000, 11'd32,   11'd33,   32'h5555_5555};
    vecs[2] = '{6'd63, 16'hAAAA, 16'hAAAA, 11'd1024, 11'd1025, 32'h5555_5555};
    vecs[3] = '{6'd1,  16'h0000, 16'hFFFF, 11'd1,    11'd0,    32'hAAAA_AAAA};
    vecs[4] = '{6'd7,  16'h0F0F, 16'h0000, 11'd63,   11'd65,   32'h5555_5555};
    vecs[5] = '{6'd2,  16'hFFFF, 16'h0000, 11'd2047, 11'd2047, 32'h0000_0000};

    rst = 1'b1; start = 1'b0; batch = '0; threshold = '0;
    activation_in = '0; weight_in = '0; activation_in_valid = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_out_bits", 64'(out_bits), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_overrun", 64'(overrun), 64'(0));

    for (int t = 0; t < 6; t++) begin
      prev = out_cnt;
      exp_q.push_back(vecs[t].exp_bits);
      start_job(vecs[t].batch, vecs[t].thr_even, vecs[t].thr_odd);
      check("busy_after_start", 64'(busy), 64'(1));
      for (int b = 0; b <= int'(vecs[t].batch); b++) drive_beat('1, vecs[t].act, vecs[t].w);
      activation_in_valid = '0;
      wait_out(prev, 10);
      check("latency_c_plus_3", 64'(last_out_cyc - last_valid_cyc), 64'(3));
      tick();
      check("busy_after_emit", 64'(busy), 64'(0));
      check("out_valid_one_cycle", 64'(out_valid), 64'(0));
      check("out_bits_hold", 64'(out_bits), 64'(vecs[t].exp_bits));
      check("no_overrun", 64'(overrun), 64'(0));
    end

    // Skewed lanes: lane i valid at relative steps i and i+1.
    prev = out_cnt;
    exp_q.push_back(32'hFFFF_FFFF);
    start_job(6'd1, 11'd32, 11'd32);
    for (int t = 0; t <= LANES; t++) begin
      for (int i = 0; i < LANES; i++) vmask[i] = (t == i) || (t == i + 1);
      drive_beat(vmask, 16'hFFFF, 16'hFFFF);
      if (t == 16) check("skew_busy_mid", 64'(busy), 64'(1));
    end
    activation_in_valid = '0;
    wait_out(prev, 10);
    check("skew_latency", 64'(last_out_cyc - last_valid_cyc), 64'(3));
    repeat (5) tick();
    check("skew_single_out", 64'(out_cnt - prev), 64'(1));
    check("skew_busy_low", 64'(busy), 64'(0));

    // Extra beat on lane 7: second beat must be dropped (acc7 = 8 < 9).
    prev = out_cnt;
    exp_q.push_back(32'hFFFF_FF7F);
    start_job(6'd0, 11'd9, 11'd9);
    activation_in = {LANES{16'hFFFF}};
    weight_in = {LANES{16'hFFFF}};
    activation_in[WIDTH*7 +: WIDTH] = 16'h00FF;
    weight_in[WIDTH*7 +: WIDTH] = 16'h0000;
    activation_in_valid = '1;
    tick();
    activation_in = {LANES{16'hFFFF}};
    weight_in = {LANES{16'hFFFF}};
    activation_in_valid = 32'h0000_0080;
    tick();
    activation_in_valid = '0;
    wait_out(prev, 10);
    check("extra_beat_overrun", 64'(overrun), 64'(1));
    repeat (5) tick();
    check("extra_beat_single_out", 64'(out_cnt - prev), 64'(1));

    // start during RUN must not relatch batch or threshold.
    prev = out_cnt;
    exp_q.push_back(32'hFFFF_FFFF);
    start_job(6'd1, 11'd32, 11'd32);
    check("overrun_cleared_by_start", 64'(overrun), 64'(0));
    drive_beat('1, 16'hFFFF, 16'hFFFF);
    start = 1'b1; batch = 6'd0; threshold = '1;
    drive_beat('1, 16'hFFFF, 16'hFFFF);
    start = 1'b0;
    activation_in_valid = '0;
    wait_out(prev, 10);
    check("restart_latency", 64'(last_out_cyc - last_valid_cyc), 64'(3));
    check("restart_no_overrun", 64'(overrun), 64'(0));
    tick();
    activation_in_valid = 32'h0000_0001;
    tick();
    activation_in_valid = '0;
    tick();
    check("idle_valid_overrun", 64'(overrun), 64'(1));

    // Reset mid-RUN after 2 of 4 beats: no output, then a fresh job from zero.
    prev = out_cnt;
    start_job(6'd3, 11'd0, 11'd0);
    check("overrun_cleared_on_start", 64'(overrun), 64'(0));
    drive_beat('1, 16'hFFFF, 16'hFFFF);
    drive_beat('1, 16'hFFFF, 16'hFFFF);
    activation_in_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("rst_no_out_valid", 64'(out_cnt), 64'(prev));
    check("rst_busy_low", 64'(busy), 64'(0));
    check("rst_out_bits_clear", 64'(out_bits), 64'(0));
    prev = out_cnt;
    exp_q.push_back(32'h5555_5555);
    start_job(6'd3, 11'd32, 11'd33);
    for (int b = 0; b < 4; b++) drive_beat('1, 16'h00FF, 16'h0000);
    activation_in_valid = '0;
    wait_out(prev, 10);
    check("post_rst_latency", 64'(last_out_cyc - last_valid_cyc), 64'(3));

    repeat (4) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
